// File: rtl/lif_pkg.sv
// Shared constants and helpers for the LIF neuron blocks.
package lif_pkg;

  // Membrane potentials and currents are signed Q(W-4).4.
  localparam int FRAC_BITS   = 4;
  localparam int THRESH_DEF  = 4 << FRAC_BITS;
  localparam int V_MAX_DEF   = 127;
  localparam int V_MIN_DEF   = -128;
  localparam int V_RESET_DEF = 0;

  // Refractory counter width; REFRAC must fit (0..15).
  localparam int REF_W = 4;

  // Clamp a signed value into [lo, hi].
  function automatic int saturate(input int s, input int lo, input int hi);
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational single-neuron step: leak, integrate, saturate, threshold.
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int W       = 8,
  parameter int LEAK_SH = 3,
  parameter int THRESH  = THRESH_DEF,
  parameter int V_MAX   = V_MAX_DEF,
  parameter int V_MIN   = V_MIN_DEF,
  parameter int V_RESET = V_RESET_DEF,
  parameter int REFRAC  = 2
) (
  input  logic [W-1:0]     v_in,
  input  logic [W-1:0]     i_in,
  input  logic [REF_W-1:0] ref_in,
  output logic [W-1:0]     v_out,
  output logic [REF_W-1:0] ref_out,
  output logic             fire
);

  // Two guard bits cover V - leak + I for any W-bit operands.
  localparam int SW = W + 2;
  localparam logic signed [W-1:0] THRESH_W  = W'(THRESH);
  localparam logic signed [W-1:0] V_RESET_W = W'(V_RESET);

  logic signed [SW-1:0] v_ext;
  logic signed [SW-1:0] i_ext;
  logic signed [SW-1:0] leak;
  logic signed [SW-1:0] sum;
  logic signed [W-1:0]  v_n;

  // Leak/integrate/saturate candidate potential.
  always_comb begin
    v_ext = {{2{v_in[W-1]}}, v_in};
    i_ext = {{2{i_in[W-1]}}, i_in};
    leak  = v_ext >>> LEAK_SH;
    sum   = v_ext - leak + i_ext;
    v_n   = W'(saturate(int'(sum), V_MIN, V_MAX));
  end

  // Refractory hold takes priority over integration; otherwise threshold the candidate.
  always_comb begin
    v_out   = v_in;
    ref_out = ref_in;
    fire    = 1'b0;
    if (ref_in != '0) begin
      ref_out = ref_in - REF_W'(1);
      v_out   = V_RESET_W;
    end else if (v_n >= THRESH_W) begin
      fire    = 1'b1;
      v_out   = V_RESET_W;
      ref_out = REF_W'(REFRAC);
    end else begin
      v_out   = v_n;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of LIF neurons sharing one update unit.
// One neuron per enabled cycle is stepped, round robin from index 0.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int W         = 8,
  parameter int LEAK_SH   = 3,
  parameter int THRESH    = THRESH_DEF,
  parameter int V_MAX     = V_MAX_DEF,
  parameter int V_MIN     = V_MIN_DEF,
  parameter int V_RESET   = V_RESET_DEF,
  parameter int REFRAC    = 2,
  parameter int IDXW      = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDXW-1:0]      in_idx,
  input  logic [W-1:0]         in_cur,
  output logic                 spk_valid,
  output logic [IDXW-1:0]      spk_idx,
  output logic                 sweep_done,
  output logic [N_NEURONS-1:0] refractory,
  input  logic [IDXW-1:0]      dbg_sel,
  output logic [W-1:0]         dbg_v
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);

  logic [W-1:0]     v_q   [N_NEURONS];
  logic [W-1:0]     v_d   [N_NEURONS];
  logic [W-1:0]     i_q   [N_NEURONS];
  logic [W-1:0]     i_d   [N_NEURONS];
  logic [REF_W-1:0] ref_q [N_NEURONS];
  logic [REF_W-1:0] ref_d [N_NEURONS];

  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic             spk_valid_q, spk_valid_d;
  logic [IDXW-1:0]  spk_idx_q, spk_idx_d;
  logic             sweep_done_q, sweep_done_d;

  logic [W-1:0]     cur_v;
  logic [W-1:0]     cur_i;
  logic [REF_W-1:0] cur_ref;
  logic [W-1:0]     upd_v;
  logic [REF_W-1:0] upd_ref;
  logic             upd_fire;

  // Fetch the state of the neuron under the scheduler pointer.
  always_comb begin
    cur_v   = v_q[ptr_q];
    cur_i   = i_q[ptr_q];
    cur_ref = ref_q[ptr_q];
  end

  lif_update_unit #(
    .W       (W),
    .LEAK_SH (LEAK_SH),
    .THRESH  (THRESH),
    .V_MAX   (V_MAX),
    .V_MIN   (V_MIN),
    .V_RESET (V_RESET),
    .REFRAC  (REFRAC)
  ) u_update (
    .v_in    (cur_v),
    .i_in    (cur_i),
    .ref_in  (cur_ref),
    .v_out   (upd_v),
    .ref_out (upd_ref),
    .fire    (upd_fire)
  );

  // Next state: write back the stepped neuron, advance the pointer, latch events, take current writes.
  // The update reads i_q, so a same-cycle write to the active neuron lands for its next slot.
  always_comb begin
    v_d          = v_q;
    i_d          = i_q;
    ref_d        = ref_q;
    ptr_d        = ptr_q;
    spk_valid_d  = 1'b0;
    spk_idx_d    = spk_idx_q;
    sweep_done_d = 1'b0;
    if (en) begin
      v_d[ptr_q]   = upd_v;
      ref_d[ptr_q] = upd_ref;
      spk_valid_d  = upd_fire;
      if (upd_fire) begin
        spk_idx_d = ptr_q;
      end
      sweep_done_d = (ptr_q == LAST_IDX);
      ptr_d        = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDXW'(1);
    end
    if (in_valid && (int'(in_idx) < N_NEURONS)) begin
      i_d[in_idx] = in_cur;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k]   <= '0;
        i_q[k]   <= '0;
        ref_q[k] <= '0;
      end
      ptr_q        <= '0;
      spk_valid_q  <= 1'b0;
      spk_idx_q    <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      v_q          <= v_d;
      i_q          <= i_d;
      ref_q        <= ref_d;
      ptr_q        <= ptr_d;
      spk_valid_q  <= spk_valid_d;
      spk_idx_q    <= spk_idx_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  // Per-neuron refractory flags and the debug potential read.
  always_comb begin
    refractory = '0;
    dbg_v      = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      refractory[k] = (ref_q[k] != '0);
      if (dbg_sel == IDXW'(k)) begin
        dbg_v = v_q[k];
      end
    end
  end

  assign in_ready   = ~rst;
  assign spk_valid  = spk_valid_q;
  assign spk_idx    = spk_idx_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array (N=4, W=8, LEAK_SH=3, THRESH=64, REFRAC=2).
module tb_lif_neuron_array;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IDXW-1:0] in_idx = '0;
  logic [W-1:0]    in_cur = '0;
  logic            spk_valid;
  logic [IDXW-1:0] spk_idx;
  logic            sweep_done;
  logic [N-1:0]    refractory;
  logic [IDXW-1:0] dbg_sel = '0;
  logic [W-1:0]    dbg_v;

  int checks = 0;
  int errors = 0;
  int n_spk = 0;
  int n_sweep = 0;

  // Reference model state and spike scoreboard
  int mv[N];
  int mi[N];
  int mref[N];
  int mptr = 0;
  int exp_sweep = 0;
  int exp_q[$];

  typedef struct {
    int cyc;
    bit en;
    bit wr;
    int widx;
    int wcur;
    int exp_v0;
    int exp_ref0;
  } vec_t;
  vec_t vt[9];

  always #10 clk = ~clk;

  lif_neuron_array #(
    .N_NEURONS (N),
    .W         (W),
    .LEAK_SH   (3),
    .THRESH    (64),
    .V_MAX     (127),
    .V_MIN     (-128),
    .V_RESET   (0),
    .REFRAC    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_cur     (in_cur),
    .spk_valid  (spk_valid),
    .spk_idx    (spk_idx),
    .sweep_done (sweep_done),
    .refractory (refractory),
    .dbg_sel    (dbg_sel),
    .dbg_v      (dbg_v)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_v(input int idx, input int exp, input string name);
    dbg_sel = idx[IDXW-1:0];
    #1;
    chk(name, int'($signed(dbg_v)), exp);
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      mv[k] = 0;
      mi[k] = 0;
      mref[k] = 0;
    end
    mptr = 0;
    exp_q.delete();
  endtask

  // One clock: step the model with the inputs now applied, clock the DUT, compare at the negedge.
  task automatic cycle();
    int s;
    exp_sweep = 0;
    if (en) begin
      if (mref[mptr] != 0) begin
        mref[mptr] = mref[mptr] - 1;
        mv[mptr] = 0;
      end else begin
        s = mv[mptr] - (mv[mptr] >>> 3) + mi[mptr];
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        if (s >= 64) begin
          mv[mptr] = 0;
          mref[mptr] = 2;
          exp_q.push_back(mptr);
        end else begin
          mv[mptr] = s;
        end
      end
      exp_sweep = (mptr == N - 1) ? 1 : 0;
      mptr = (mptr + 1) % N;
    end
    if (in_valid) mi[in_idx] = int'($signed(in_cur));
    @(posedge clk);
    @(negedge clk);
    if (spk_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spk_unexpected actual idx=%0d required none", spk_idx);
      end else begin
        chk("spk_idx", int'(spk_idx), exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL spk_missing actual none required idx=%0d", exp_q.pop_front());
    end
    chk("sweep_done", int'(sweep_done), exp_sweep);
    for (int k = 0; k < N; k++) chk("refractory", int'(refractory[k]), (mref[k] != 0) ? 1 : 0);
    chk("in_ready", int'(in_ready), 1);
    n_spk += int'(spk_valid);
    n_sweep += int'(sweep_done);
  endtask

  task automatic run(input int n, input bit e);
    en = e;
    repeat (n) cycle();
  endtask

  task automatic wr(input int idx, input int cur, input bit e);
    en = e;
    in_valid = 1'b1;
    in_idx = idx[IDXW-1:0];
    in_cur = cur[W-1:0];
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_spk_valid", int'(spk_valid), 0);
    chk("rst_spk_idx", int'(spk_idx), 0);
    chk("rst_sweep_done", int'(sweep_done), 0);
    chk("rst_refractory", int'(refractory), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    for (int k = 0; k < N; k++) chk_v(k, 0, "rst_v");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_spk_valid", int'(spk_valid), 0);
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    #2;
    do_reset();

    // Test 1/2: I0=16 integration, spike, refractory and recovery (hand-computed V0)
    vt[0] = '{1, 1'b0, 1'b1, 0, 16, 0,  0};
    vt[1] = '{1, 1'b1, 1'b0, 0, 0,  16, 0};
    vt[2] = '{4, 1'b1, 1'b0, 0, 0,  30, 0};
    vt[3] = '{4, 1'b1, 1'b0, 0, 0,  43, 0};
    vt[4] = '{4, 1'b1, 1'b0, 0, 0,  54, 0};
    vt[5] = '{4, 1'b1, 1'b0, 0, 0,  0,  1};
    vt[6] = '{4, 1'b1, 1'b0, 0, 0,  0,  1};
    vt[7] = '{4, 1'b1, 1'b0, 0, 0,  0,  0};
    vt[8] = '{4, 1'b1, 1'b0, 0, 0,  16, 0};
    n_spk = 0;
    for (int r = 0; r < 9; r++) begin
      if (vt[r].wr) begin
        wr(vt[r].widx, vt[r].wcur, vt[r].en);
        run(vt[r].cyc - 1, vt[r].en);
      end else begin
        run(vt[r].cyc, vt[r].en);
      end
      chk_v(0, vt[r].exp_v0, "t1_v0");
      chk("t1_ref0", int'(refractory[0]), vt[r].exp_ref0);
    end
    chk("t1_spike_count", n_spk, 1);
    for (int k = 1; k < N; k++) chk_v(k, 0, "t2_v_other");

    // Test 3: I2=-128 saturates at V_MIN without wrapping
    do_reset();
    wr(2, -128, 1'b0);
    n_spk = 0;
    run(3, 1'b1);
    chk_v(2, -128, "t3_v2_first");
    run(4, 1'b1);
    chk_v(2, -128, "t3_v2_sat");
    run(8, 1'b1);
    chk_v(2, -128, "t3_v2_sat_hold");
    chk("t3_spike_count", n_spk, 0);

    // Test 4: I1=127 fires every third slot; sweep_done every 4 cycles
    do_reset();
    wr(1, 127, 1'b0);
    n_spk = 0;
    n_sweep = 0;
    run(28, 1'b1);
    chk("t4_spike_count", n_spk, 3);
    chk("t4_sweep_count", n_sweep, 7);

    // Test 5: en low for 10 cycles while I3 is rewritten
    do_reset();
    wr(3, 16, 1'b0);
    run(4, 1'b1);
    chk_v(3, 16, "t5_v3_before");
    run(2, 1'b1);
    n_spk = 0;
    n_sweep = 0;
    run(4, 1'b0);
    wr(3, 32, 1'b0);
    run(5, 1'b0);
    chk_v(3, 16, "t5_v3_hold");
    chk("t5_spk_during_hold", n_spk, 0);
    chk("t5_sweep_during_hold", n_sweep, 0);
    run(2, 1'b1);
    chk_v(3, 46, "t5_v3_resume");

    // Same-slot write: update uses the old current
    do_reset();
    wr(0, 16, 1'b1);
    chk_v(0, 0, "same_slot_old_i");
    run(4, 1'b1);
    chk_v(0, 16, "same_slot_next");

    // Test 6: reset while V0=54 and the firing slot is next
    do_reset();
    wr(0, 16, 1'b0);
    run(13, 1'b1);
    chk_v(0, 54, "t6_v0_54");
    run(3, 1'b1);
    chk_v(0, 54, "t6_v0_pending");
    do_reset();
    wr(0, 16, 1'b0);
    run(1, 1'b1);
    chk_v(0, 16, "t6_restart_v0");
    run(16, 1'b1);
    chk("t6_spk_before_rst", int'(spk_valid), 1);
    do_reset();
    run(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
